// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches from RAM, evaluates the condition
// field against the flag register and steps through EXEC/MEM/WB.
module cpu_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        run,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [15:0] ram_addr,
  input  logic [31:0] ram_rdata,
  input  logic [15:0] mem_addr,
  input  logic [3:0]  new_flag,
  output logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [3:0]  opcode,
  output logic        s,
  output logic [3:0]  dest,
  output logic [3:0]  src2,
  output logic [3:0]  src1,
  output logic [4:0]  iv,
  output logic [3:0]  flags,
  output logic        reg_we,
  output logic        ldr,
  output logic        str,
  output logic [7:0]  pc,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDR  = 4'hC;
  localparam logic [3:0] OP_STR  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_reg;
  logic [7:0]  pc_reg;
  logic [31:0] instr_reg;
  logic [3:0]  flags_reg;

  logic        flag_n, flag_z, flag_c, flag_v;
  logic [15:0] cond_table;
  logic [3:0]  fetch_cond;
  logic [3:0]  fetch_opcode;
  logic        cond_pass;
  logic        is_ldr, is_str, is_mem_op;

  assign flag_n = flags_reg[3];
  assign flag_z = flags_reg[2];
  assign flag_c = flags_reg[1];
  assign flag_v = flags_reg[0];

  // The word is still on ram_rdata during DECODE, so the condition is judged
  // on the incoming fields rather than on the not-yet-latched instr register.
  assign fetch_cond   = ram_rdata[31:28];
  assign fetch_opcode = ram_rdata[27:24];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_cond
      if (gi == 0)      begin : g_al assign cond_table[gi] = 1'b1;     end
      else if (gi == 1) begin : g_eq assign cond_table[gi] = flag_z;   end
      else if (gi == 2) begin : g_ne assign cond_table[gi] = !flag_z;  end
      else if (gi == 3) begin : g_cs assign cond_table[gi] = flag_c;   end
      else if (gi == 4) begin : g_cc assign cond_table[gi] = !flag_c;  end
      else if (gi == 5) begin : g_mi assign cond_table[gi] = flag_n;   end
      else if (gi == 6) begin : g_pl assign cond_table[gi] = !flag_n;  end
      else if (gi == 7) begin : g_vs assign cond_table[gi] = flag_v;   end
      else if (gi == 8) begin : g_vc assign cond_table[gi] = !flag_v;  end
      else              begin : g_nv assign cond_table[gi] = 1'b0;     end
    end
  endgenerate

  assign cond_pass = cond_table[fetch_cond];

  assign is_ldr    = (instr_reg[27:24] == OP_LDR);
  assign is_str    = (instr_reg[27:24] == OP_STR);
  assign is_mem_op = is_ldr || is_str;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= 8'h00;
      instr_reg <= 32'h0000_0000;
      flags_reg <= 4'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (run) state_reg <= S_FETCH;
        end
        S_FETCH: begin
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          instr_reg <= ram_rdata;
          pc_reg    <= pc_reg + 8'd1;
          if (!cond_pass)
            state_reg <= S_FETCH;
          else if (fetch_opcode == OP_HALT)
            state_reg <= S_HALT;
          else
            state_reg <= S_EXEC;
        end
        S_EXEC: begin
          if (instr_reg[23] && !is_mem_op) flags_reg <= new_flag;
          state_reg <= is_mem_op ? S_MEM : S_WB;
        end
        S_MEM: begin
          state_reg <= S_WB;
        end
        S_WB: begin
          state_reg <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode the state register; gating with Reset keeps them quiet
  // in the cycle a reset is being applied, even mid-MEM.
  always_comb begin
    ram_en   = 1'b0;
    ram_rw   = 1'b1;
    ram_addr = 16'h0000;
    reg_we   = 1'b0;
    ldr      = 1'b0;
    str      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ram_en   = Reset;
        ram_addr = {8'h00, pc_reg};
      end
      S_MEM: begin
        ram_en   = Reset;
        ram_rw   = !is_str;
        ram_addr = mem_addr;
        str      = Reset && is_str;
      end
      S_WB: begin
        reg_we = Reset && !is_str;
        ldr    = Reset && is_ldr;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  assign halted = (state_reg == S_HALT);
  assign state  = state_reg;
  assign pc     = pc_reg;
  assign flags  = flags_reg;
  assign instr  = instr_reg;
  assign cond   = instr_reg[31:28];
  assign opcode = instr_reg[27:24];
  assign s      = instr_reg[23];
  assign dest   = instr_reg[22:19];
  assign src2   = instr_reg[18:15];
  assign src1   = instr_reg[14:11];
  assign iv     = instr_reg[10:6];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small synchronous-read RAM model.
module tb_cpu_sequencer;

  logic        Clk;
  logic        Reset;
  logic        run;
  logic        ram_en;
  logic        ram_rw;
  logic [15:0] ram_addr;
  logic [31:0] ram_rdata;
  logic [15:0] mem_addr;
  logic [3:0]  new_flag;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s;
  logic [3:0]  dest;
  logic [3:0]  src2;
  logic [3:0]  src1;
  logic [4:0]  iv;
  logic [3:0]  flags;
  logic        reg_we;
  logic        ldr;
  logic        str;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        halted;

  logic [31:0] mem [0:255];
  int n_cmp;
  int n_err;

  cpu_sequencer dut (
    .Clk(Clk), .Reset(Reset), .run(run),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .mem_addr(mem_addr), .new_flag(new_flag),
    .instr(instr), .cond(cond), .opcode(opcode), .s(s), .dest(dest),
    .src2(src2), .src1(src1), .iv(iv), .flags(flags),
    .reg_we(reg_we), .ldr(ldr), .str(str), .pc(pc), .state(state), .halted(halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Read data appears the cycle after a read-enable, as a block RAM would give it.
  always @(posedge Clk) begin
    if (ram_en && ram_rw) ram_rdata <= mem[ram_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    bit found;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[0]    = 32'h0628_0060;  // ALU op, cond AL
    mem[1]    = 32'h0C00_0000;  // LDR, cond AL
    mem[2]    = 32'h1600_0000;  // ALU op, cond EQ (Z clear -> skipped)
    mem[3]    = 32'h0680_0000;  // ALU op with s=1
    mem[4]    = 32'h1600_0000;  // ALU op, cond EQ (Z set -> runs)
    mem[5]    = 32'h0D00_0000;  // STR, cond AL
    mem[8'h40] = 32'hDEAD_BEEF;

    Reset = 1'b0; run = 1'b0; mem_addr = 16'h0000; new_flag = 4'h0;
    cyc(); cyc();
    check("rst_state",  32'(state),    32'd0);
    check("rst_pc",     32'(pc),       32'd0);
    check("rst_instr",  instr,         32'd0);
    check("rst_flags",  32'(flags),    32'd0);
    check("rst_ram_en", 32'(ram_en),   32'd0);
    check("rst_ram_rw", 32'(ram_rw),   32'd1);
    check("rst_addr",   32'(ram_addr), 32'd0);
    check("rst_halted", 32'(halted),   32'd0);
    check("rst_reg_we", 32'(reg_we),   32'd0);

    // ALU op: FETCH, DECODE, EXEC, WB
    Reset = 1'b1; run = 1'b1;
    cyc();
    check("alu_fetch_state", 32'(state),    32'd1);
    check("alu_fetch_en",    32'(ram_en),   32'd1);
    check("alu_fetch_addr",  32'(ram_addr), 32'h0000);
    cyc();
    check("alu_decode_state", 32'(state),  32'd2);
    check("alu_decode_we",    32'(reg_we), 32'd0);
    cyc();
    check("alu_exec_state", 32'(state), 32'd3);
    check("alu_instr",      instr,      32'h0628_0060);
    check("alu_pc",         32'(pc),    32'd1);
    check("alu_dest",       32'(dest),  32'd5);
    check("alu_iv",         32'(iv),    32'd1);
    cyc();
    check("alu_wb_state", 32'(state),  32'd5);
    check("alu_wb_we",    32'(reg_we), 32'd1);
    check("alu_wb_ldr",   32'(ldr),    32'd0);

    // LDR: five cycles with a read at mem_addr in MEM
    cyc();
    check("ldr_fetch_addr", 32'(ram_addr), 32'h0001);
    check("ldr_fetch_we",   32'(reg_we),   32'd0);
    cyc();
    mem_addr = 16'h0040;
    cyc();
    check("ldr_exec_state", 32'(state), 32'd3);
    cyc();
    check("ldr_mem_state", 32'(state),    32'd4);
    check("ldr_mem_en",    32'(ram_en),   32'd1);
    check("ldr_mem_rw",    32'(ram_rw),   32'd1);
    check("ldr_mem_addr",  32'(ram_addr), 32'h0040);
    check("ldr_mem_str",   32'(str),      32'd0);
    cyc();
    check("ldr_wb_state", 32'(state),     32'd5);
    check("ldr_wb_ldr",   32'(ldr),       32'd1);
    check("ldr_wb_we",    32'(reg_we),    32'd1);
    check("ldr_wb_data",  ram_rdata,      32'hDEAD_BEEF);

    // EQ with Z clear: two cycles, no strobes
    cyc();
    check("skip_fetch_pc", 32'(pc), 32'd2);
    cyc();
    check("skip_decode_state", 32'(state), 32'd2);
    cyc();
    check("skip_back_fetch", 32'(state),    32'd1);
    check("skip_pc",         32'(pc),       32'd3);
    check("skip_addr",       32'(ram_addr), 32'h0003);
    check("skip_we",         32'(reg_we),   32'd0);
    check("skip_flags",      32'(flags),    32'd0);

    // s=1 ALU op loads new_flag at end of EXEC
    cyc();
    new_flag = 4'b0100;
    cyc();
    check("sflag_exec_state", 32'(state), 32'd3);
    check("sflag_s",          32'(s),     32'd1);
    check("sflag_pre",        32'(flags), 32'd0);
    cyc();
    check("sflag_flags", 32'(flags),  32'h4);
    check("sflag_we",    32'(reg_we), 32'd1);
    new_flag = 4'b0000;

    // EQ now passes because Z is set
    cyc();
    cyc();
    cyc();
    check("eq_exec_state", 32'(state), 32'd3);
    check("eq_pc",         32'(pc),    32'd5);
    cyc();
    check("eq_wb_we",    32'(reg_we), 32'd1);
    check("eq_flags_kept", 32'(flags), 32'h4);

    // STR interrupted by reset during MEM
    cyc();
    cyc();
    mem_addr = 16'h0080;
    cyc();
    check("str_exec_state", 32'(state), 32'd3);
    cyc();
    check("str_mem_state", 32'(state),    32'd4);
    check("str_mem_rw",    32'(ram_rw),   32'd0);
    check("str_mem_str",   32'(str),      32'd1);
    check("str_mem_addr",  32'(ram_addr), 32'h0080);
    Reset = 1'b0;
    #1;
    check("str_rst_str_gated", 32'(str),    32'd0);
    check("str_rst_en_gated",  32'(ram_en), 32'd0);
    cyc();
    check("str_rst_state", 32'(state),  32'd0);
    check("str_rst_pc",    32'(pc),     32'd0);
    check("str_rst_str",   32'(str),    32'd0);
    check("str_rst_we",    32'(reg_we), 32'd0);
    check("str_rst_flags", 32'(flags),  32'd0);
    cyc();
    check("str_rst_hold", 32'(state), 32'd0);

    // pc wrap through 255 never-executed words, HALT at 8'hFF
    for (int i = 0; i < 255; i++) mem[i] = 32'h9000_0000;
    mem[255] = 32'h0F00_0000;
    Reset = 1'b1; run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      cyc();
      if (state == 3'd1 && pc == 8'hFF) found = 1'b1;
    end
    check("wrap_reach_ff", 32'(found),    32'd1);
    check("wrap_fetch_addr", 32'(ram_addr), 32'h00FF);
    cyc();
    cyc();
    check("halt_state",  32'(state),  32'd6);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc",     32'(pc),     32'd0);
    check("halt_en",     32'(ram_en), 32'd0);
    run = 1'b0;
    cyc(); cyc();
    run = 1'b1;
    cyc(); cyc();
    check("halt_run_state", 32'(state),  32'd6);
    check("halt_run_we",    32'(reg_we), 32'd0);
    check("halt_run_pc",    32'(pc),     32'd0);
    Reset = 1'b0;
    cyc();
    check("halt_rst_state",  32'(state),  32'd0);
    check("halt_rst_halted", 32'(halted), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
